fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 icache_stall  in  1  icache waiting for data; fetch address cannot change.
REQ-005 if_stall_i  in  1  controller stall of the IF stage.
REQ-006 branch_en  in  1  branch-taken redirect request, single-cycle pulse.
REQ-007 branch_pc_i  in  32  branch target, valid with branch_en.
REQ-008 pc_flush_i  in  1  exception/eret flush request, single-cycle pulse.
REQ-009 flush_pc_i  in  32  flush target, valid with pc_flush_i.
REQ-010 slot_done_i  in  1  delay-slot instruction of the pending branch accepted into IF.
REQ-011 redir_valid_o  out  1  registered one-cycle redirect command to pc.
REQ-012 redir_pc_o  out  32  redirect target, meaningful when redir_valid_o=1.
REQ-013 redir_is_flush_o  out  1  1 = redirect originates from a flush, 0 = from a branch.
REQ-014 squash_o  out  1  the fetched word in IF must be discarded (HOLD or ISSUE and pending flush).
REQ-015 busy_o  out  1  state != IDLE.
REQ-016 drop_cnt_o  out  8  saturating count of branch requests discarded or overwritten.

Function
REQ-017 fetch_free SHALL be defined as !icache_stall && !if_stall_i.
REQ-018 The FSM SHALL have three states: IDLE, HOLD and ISSUE; the registers SHALL be tgt_pc[31:0], is_flush and need_slot.
REQ-019 Capture from any state: pc_flush_i SHALL load tgt_pc=flush_pc_i, is_flush=1, need_slot=0, next=HOLD.
REQ-020 Capture of a branch_en without pc_flush_i SHALL load tgt_pc=branch_pc_i, is_flush=0, need_slot=!slot_done_i, next=HOLD, except when HOLD with is_flush=1.
REQ-021 branch_en and pc_flush_i in the same cycle: the flush SHALL win, the branch SHALL be dropped, and drop_cnt_o SHALL be incremented.
REQ-022 branch_en in HOLD with is_flush=1: the branch SHALL be ignored and drop_cnt_o SHALL be incremented.
REQ-023 branch_en in HOLD with is_flush=0: the new branch SHALL overwrite the held one and drop_cnt_o SHALL be incremented.
REQ-024 A newer flush in HOLD SHALL overwrite any held target, and drop_cnt_o SHALL be incremented only if the held target was a branch.
REQ-025 HOLD, no new request, slot_done_i=1: need_slot SHALL clear.
REQ-026 HOLD->ISSUE SHALL occur when fetch_free=1, there is no new request that cycle, and need_slot=0 (slot_done_i in the same cycle counts as cleared).
REQ-027 HOLD with the exit condition false SHALL stay in HOLD, for an unbounded time.
REQ-028 ISSUE SHALL last exactly one cycle with redir_valid_o=1, redir_pc_o=tgt_pc and redir_is_flush_o=is_flush.
REQ-029 ISSUE with no request SHALL go to IDLE; ISSUE with a request SHALL capture per REQ-019/020 and go to HOLD.
REQ-030 redir_pc_o and redir_is_flush_o SHALL hold their last values outside ISSUE, and redir_valid_o SHALL be 0 outside ISSUE.
REQ-031 squash_o SHALL equal (state==HOLD || state==ISSUE) && (is_flush || !need_slot), so the delay slot is never squashed.
REQ-032 Minimum latency SHALL be: request at edge N, HOLD during cycle N+1, ISSUE (redir_valid_o=1) during cycle N+2 when fetch_free=1 and need_slot=0 in N+1.
REQ-033 drop_cnt_o SHALL saturate at 8'hFF and never wrap.
REQ-034 Each cycle SHALL add at most 1 to drop_cnt_o.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state=IDLE, tgt_pc=0, is_flush=0, need_slot=0, all outputs 0, drop_cnt_o=0.
REQ-036 Reset during HOLD or ISSUE SHALL discard the pending redirect, with no redir_valid_o after release.
REQ-037 Requests sampled while rst_n=0 SHALL be ignored.

Verification
REQ-038 Branch with slot_done_i=1, fetch_free=1: branch_en, branch_pc_i=32'hBFC0_0100 at edge N -> redir_valid_o=1, redir_pc_o=32'hBFC0_0100, redir_is_flush_o=0 in cycle N+2 only.
REQ-039 Branch, slot_done_i=0, icache_stall=1 for 5 cycles, then slot_done_i pulse while stalled -> no redir_valid_o until the cycle after icache_stall falls; squash_o=0 until slot done, then squash_o=1.
REQ-040 branch_en and pc_flush_i together, flush_pc_i=32'hBFC0_0380 -> single ISSUE with redir_pc_o=32'hBFC0_0380, redir_is_flush_o=1, drop_cnt_o=1.
REQ-041 Held branch (icache_stall=1), then pc_flush_i to 32'h8000_0180, then branch_en -> one ISSUE to 32'h8000_0180, drop_cnt_o=2.
REQ-042 300 dropped branches -> drop_cnt_o=8'hFF; rst_n low mid-HOLD -> all outputs 0 immediately, no redir_valid_o after release.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect bundle: IF stall/request inputs and pc redirect outputs.
// master drives requests and stalls, slave is the redirect controller.
interface fetch_redirect_ctrl_if;
  logic        icache_stall;
  logic        if_stall_i;
  logic        branch_en;
  logic [31:0] branch_pc_i;
  logic        pc_flush_i;
  logic [31:0] flush_pc_i;
  logic        slot_done_i;
  logic        redir_valid_o;
  logic [31:0] redir_pc_o;
  logic        redir_is_flush_o;
  logic        squash_o;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  modport master (
    output icache_stall, if_stall_i,
    output branch_en, branch_pc_i,
    output pc_flush_i, flush_pc_i,
    output slot_done_i,
    input  redir_valid_o, redir_pc_o,
    input  redir_is_flush_o, squash_o,
    input  busy_o, drop_cnt_o
  );

  modport slave (
    input  icache_stall, if_stall_i,
    input  branch_en, branch_pc_i,
    input  pc_flush_i, flush_pc_i,
    input  slot_done_i,
    output redir_valid_o, redir_pc_o,
    output redir_is_flush_o, squash_o,
    output busy_o, drop_cnt_o
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Holds branch/flush redirects until IF can take them, then issues one cycle.
// Ports: clk, rst_n (async low), bus (fetch_redirect_ctrl_if.slave).
module fetch_redirect_ctrl (
  input logic                 clk,
  input logic                 rst_n,
  fetch_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ISSUE
  } state_t;

  state_t      state, state_n;
  logic [31:0] tgt_pc, tgt_pc_n;
  logic [31:0] out_pc, out_pc_n;
  logic        is_flush, is_flush_n;
  logic        need_slot, need_slot_n;
  logic        out_flush, out_flush_n;
  logic [7:0]  drop_cnt;
  logic        drop;
  logic        fetch_free;
  logic        held_br;

  assign fetch_free = !bus.icache_stall
                    && !bus.if_stall_i;
  assign held_br = (state == HOLD) && !is_flush;

  always_comb begin
    state_n     = state;
    tgt_pc_n    = tgt_pc;
    is_flush_n  = is_flush;
    need_slot_n = need_slot;
    out_pc_n    = out_pc;
    out_flush_n = out_flush;
    drop        = 1'b0;
    if (bus.pc_flush_i) begin
      tgt_pc_n    = bus.flush_pc_i;
      is_flush_n  = 1'b1;
      need_slot_n = 1'b0;
      state_n     = HOLD;
      drop        = bus.branch_en || held_br;
    end else if (bus.branch_en) begin
      drop = (state == HOLD);
      // A held flush always outranks a later branch.
      if (!((state == HOLD) && is_flush)) begin
        tgt_pc_n    = bus.branch_pc_i;
        is_flush_n  = 1'b0;
        need_slot_n = !bus.slot_done_i;
        state_n     = HOLD;
      end
    end else begin
      case (state)
        HOLD: begin
          if (bus.slot_done_i) need_slot_n = 1'b0;
          if (fetch_free && !need_slot_n) begin
            state_n     = ISSUE;
            out_pc_n    = tgt_pc;
            out_flush_n = is_flush;
          end
        end
        ISSUE:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt_pc    <= '0;
      is_flush  <= 1'b0;
      need_slot <= 1'b0;
      out_pc    <= '0;
      out_flush <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      tgt_pc    <= tgt_pc_n;
      is_flush  <= is_flush_n;
      need_slot <= need_slot_n;
      out_pc    <= out_pc_n;
      out_flush <= out_flush_n;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.redir_valid_o    = (state == ISSUE);
  assign bus.redir_pc_o       = out_pc;
  assign bus.redir_is_flush_o = out_flush;
  assign bus.busy_o           = (state != IDLE);
  assign bus.drop_cnt_o       = drop_cnt;
  // The delay slot of a pending branch must still execute.
  assign bus.squash_o = (state != IDLE)
                      && (is_flush || !need_slot);
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed redirect scenarios.
// Expected redirects are queued by stimulus and checked by a monitor.
module tb_fetch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    int          cyc;
  } exp_t;

  exp_t q[$];

  fetch_redirect_ctrl_if bus ();

  fetch_redirect_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic fl,
                      input int c);
    exp_t e;
    e.pc = pc;
    e.fl = fl;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Monitor: every redirect must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.redir_valid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_redir: got pc %h expected none",
                 bus.redir_pc_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("redir_pc", bus.redir_pc_o, e.pc);
        chk("redir_is_flush",
            {31'd0, bus.redir_is_flush_o}, {31'd0, e.fl});
        chk("redir_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.icache_stall = 1'b0;
    bus.if_stall_i   = 1'b0;
    bus.branch_en    = 1'b0;
    bus.branch_pc_i  = '0;
    bus.pc_flush_i   = 1'b0;
    bus.flush_pc_i   = '0;
    bus.slot_done_i  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.redir_valid_o}, 32'd0);
    chk("rst_pc", bus.redir_pc_o, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_squash", {31'd0, bus.squash_o}, 32'd0);
    chk("rst_drop", {24'd0, bus.drop_cnt_o}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fast branch, slot already done.
    bus.branch_en   = 1'b1;
    bus.branch_pc_i = 32'hBFC0_0100;
    bus.slot_done_i = 1'b1;
    push(32'hBFC0_0100, 1'b0, cyc + 2);
    step();
    bus.branch_en   = 1'b0;
    bus.slot_done_i = 1'b0;
    chk("a_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("a_squash", {31'd0, bus.squash_o}, 32'd1);
    step();
    step();
    chk("a_idle", {31'd0, bus.busy_o}, 32'd0);
    chk("a_pc_hold", bus.redir_pc_o, 32'hBFC0_0100);

    // Branch waiting on its delay slot under icache stall.
    bus.icache_stall = 1'b1;
    bus.branch_en    = 1'b1;
    bus.branch_pc_i  = 32'h8000_2000;
    step();
    bus.branch_en = 1'b0;
    chk("b_squash_slot", {31'd0, bus.squash_o}, 32'd0);
    chk("b_busy", {31'd0, bus.busy_o}, 32'd1);
    step();
    step();
    bus.slot_done_i = 1'b1;
    step();
    bus.slot_done_i = 1'b0;
    chk("b_squash_after", {31'd0, bus.squash_o}, 32'd1);
    step();
    bus.icache_stall = 1'b0;
    push(32'h8000_2000, 1'b0, cyc + 1);
    step();
    step();
    step();
    chk("b_idle", {31'd0, bus.busy_o}, 32'd0);

    // Flush captured during ISSUE, then held by if_stall_i.
    bus.branch_en   = 1'b1;
    bus.branch_pc_i = 32'h0000_1111;
    bus.slot_done_i = 1'b1;
    push(32'h0000_1111, 1'b0, cyc + 2);
    step();
    bus.branch_en   = 1'b0;
    bus.slot_done_i = 1'b0;
    step();
    bus.pc_flush_i = 1'b1;
    bus.flush_pc_i = 32'h0000_2222;
    bus.if_stall_i = 1'b1;
    step();
    bus.pc_flush_i = 1'b0;
    step();
    step();
    chk("f_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("f_squash", {31'd0, bus.squash_o}, 32'd1);
    chk("f_pc_hold", bus.redir_pc_o, 32'h0000_1111);
    bus.if_stall_i = 1'b0;
    push(32'h0000_2222, 1'b1, cyc + 1);
    step();
    step();
    step();
    chk("f_idle", {31'd0, bus.busy_o}, 32'd0);
    chk("f_drop", {24'd0, bus.drop_cnt_o}, 32'd0);

    // Branch and flush together: flush wins.
    do_reset();
    bus.branch_en   = 1'b1;
    bus.branch_pc_i = 32'h1234_5678;
    bus.pc_flush_i  = 1'b1;
    bus.flush_pc_i  = 32'hBFC0_0380;
    push(32'hBFC0_0380, 1'b1, cyc + 2);
    step();
    bus.branch_en  = 1'b0;
    bus.pc_flush_i = 1'b0;
    step();
    step();
    chk("c_drop", {24'd0, bus.drop_cnt_o}, 32'd1);

    // Held branch overwritten by flush, later branch ignored.
    do_reset();
    bus.icache_stall = 1'b1;
    bus.branch_en    = 1'b1;
    bus.branch_pc_i  = 32'h0000_1234;
    bus.slot_done_i  = 1'b1;
    step();
    bus.branch_en   = 1'b0;
    bus.slot_done_i = 1'b0;
    step();
    bus.pc_flush_i = 1'b1;
    bus.flush_pc_i = 32'h8000_0180;
    step();
    bus.pc_flush_i = 1'b0;
    chk("d_drop1", {24'd0, bus.drop_cnt_o}, 32'd1);
    bus.branch_en   = 1'b1;
    bus.branch_pc_i = 32'h0000_5678;
    step();
    bus.branch_en = 1'b0;
    step();
    bus.icache_stall = 1'b0;
    push(32'h8000_0180, 1'b1, cyc + 1);
    step();
    step();
    step();
    chk("d_drop2", {24'd0, bus.drop_cnt_o}, 32'd2);

    // Saturation, then reset in HOLD.
    do_reset();
    bus.icache_stall = 1'b1;
    bus.slot_done_i  = 1'b1;
    bus.branch_en    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.branch_pc_i = 32'h9000_0000 + i;
      step();
      if (i == 254)
        chk("e_drop_fe", {24'd0, bus.drop_cnt_o}, 32'hFE);
    end
    bus.branch_en   = 1'b0;
    bus.slot_done_i = 1'b0;
    chk("e_drop_sat", {24'd0, bus.drop_cnt_o}, 32'hFF);
    chk("e_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("e_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("e_rst_squash", {31'd0, bus.squash_o}, 32'd0);
    chk("e_rst_drop", {24'd0, bus.drop_cnt_o}, 32'd0);
    chk("e_rst_valid", {31'd0, bus.redir_valid_o}, 32'd0);
    bus.icache_stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("e_post_busy", {31'd0, bus.busy_o}, 32'd0);

    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
